div64by32_seq: RTL and testbench



---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 44 ++++
 rtl/div64by32_seq.sv | 152 +++++++++++++++
 tb/tb_div64by32_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider div64by32_seq.
//   DIV_WIDTH_DEF : default divisor/quotient/remainder width (dividend is 2x)
//   divState_e    : FSM state encoding IDLE/RUN/DONE (2-bit)
//   cntWidth()    : iteration counter width, clog2(width)+1, so the counter
//                   can hold the full step count WIDTH without wrapping
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } divState_e;

  localparam int DIV_CNT_W_DEF = $clog2(DIV_WIDTH_DEF) + 1;

  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step. The partial remainder is shifted
// left by one with the quotient register's MSB entering at the bottom; the
// divisor is subtracted on a WIDTH+1-bit datapath and the result is kept only
// if it is non-negative.
// Ports:
//   rem_i     : current partial remainder R (always < divisor)
//   qMsb_i    : MSB of the quotient/dividend shift register, shifted into R
//   divisor_i : latched divisor D
//   rem_o     : next partial remainder
//   qBit_o    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             qMsb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qBit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Because R < D on entry, the shifted value is < 2D, so a non-negative
  // trial difference always fits back into WIDTH bits and the MSB of the
  // WIDTH+1-bit difference is a reliable sign bit.
  always_comb begin
    shifted = {rem_i, qMsb_i};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o  = trial[WIDTH-1:0];
      qBit_o = 1'b1;
    end else begin
      rem_o  = shifted[WIDTH-1:0];
      qBit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div64by32_seq.sv
// -----------------------------------------------------------------------------
// div64by32_seq
// Sequential restoring unsigned divider: 2*WIDTH-bit dividend divided by a
// WIDTH-bit divisor, one quotient bit per clock. Companion of the mb32_top
// multiplier: dividing its product by one operand recovers the other.
// Optional macro: DIV_BACKCHECK_EN -- when defined, the result is re-multiplied
// on entry to DONE and chk_err flags Q*D+R != dividend. When undefined chk_err
// stays 0 and no dividend copy or multiplier exists. Latency is the same.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   in_valid   : dividend/divisor valid        in_ready  : accepting (IDLE only)
//   dividend   : 2*WIDTH unsigned dividend     divisor   : WIDTH unsigned divisor
//   out_valid  : result valid (DONE)           out_ready : consumer accepts result
//   quotient   : WIDTH quotient                remainder : WIDTH remainder
//   ovf        : divide-by-zero or quotient overflow
//   chk_err    : back-check mismatch (DIV_BACKCHECK_EN builds only)
// -----------------------------------------------------------------------------
module div64by32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 ovf,
  output logic                 chk_err
);

  localparam int              CntW     = cntWidth(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  divState_e        state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CntW-1:0]  cnt_q;
  logic             outValid_q;
  logic             ovf_q;
  logic             chkErr_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             qBit;

  // The quotient register doubles as the low half of the dividend: each step
  // shifts its MSB into the remainder and the new quotient bit into its LSB.
  div_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .rem_i     (rem_q),
    .qMsb_i    (quo_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .qBit_o    (qBit)
  );

  assign quo_d = {quo_q[WIDTH-2:0], qBit};

`ifdef DIV_BACKCHECK_EN
  logic [2*WIDTH-1:0] dividend_q;
  logic               chkMismatch;

  // Evaluated on the final step's next-state values so the flag is ready in
  // the same cycle out_valid rises. Q*D+R < 2^(2*WIDTH), so no bits are lost.
  assign chkMismatch = ((({{WIDTH{1'b0}}, quo_d} * {{WIDTH{1'b0}}, divisor_q})
                         + {{WIDTH{1'b0}}, rem_d}) != dividend_q);
`endif

  // Control FSM and datapath registers. Overflow (including divide by zero)
  // is detected up front: if the high dividend half is already >= D the
  // quotient cannot fit in WIDTH bits, so the iteration is skipped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      ovf_q      <= 1'b0;
      chkErr_q   <= 1'b0;
`ifdef DIV_BACKCHECK_EN
      dividend_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            divisor_q <= divisor;
            cnt_q     <= '0;
            chkErr_q  <= 1'b0;
`ifdef DIV_BACKCHECK_EN
            dividend_q <= dividend;
`endif
            if ((divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor)) begin
              state_q    <= DONE;
              quo_q      <= '1;
              rem_q      <= '0;
              ovf_q      <= 1'b1;
              outValid_q <= 1'b1;
            end else begin
              state_q <= RUN;
              rem_q   <= dividend[2*WIDTH-1:WIDTH];
              quo_q   <= dividend[WIDTH-1:0];
              ovf_q   <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastStep) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
`ifdef DIV_BACKCHECK_EN
            chkErr_q   <= chkMismatch;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            chkErr_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          chkErr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign chk_err   = chkErr_q;

endmodule

// File: tb/tb_div64by32_seq.sv
// -----------------------------------------------------------------------------
// tb_div64by32_seq
// Scoreboarded bench for div64by32_seq: applyStimulus pushes the expected
// result when an operation is accepted; a monitor pops and checks it whenever
// the DUT presents a result, including latency from accept to out_valid.
// -----------------------------------------------------------------------------
module tb_div64by32_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ovf;
  logic        chk_err;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        ovf;
    int          acceptCycle;
    int          lat;
    int          id;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCount  = 0;
  int   nextId      = 0;
  bit   seenValid   = 1'b0;

  div64by32_seq #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .chk_err   (chk_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLK = ~CLK;

  // Cycle counter used to measure accept-to-result latency.
  always @(posedge CLK) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got no response within bound, expected response", name);
  endtask

  // Waits for in_ready, presents one operation for exactly one accepting edge,
  // then scrambles the inputs to show they are ignored once the op is in flight.
  task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input logic expOvf, input int lat, input bit track);
    int   waitCnt = 0;
    exp_t e;
    @(negedge CLK);
    while (!in_ready && waitCnt < 200) begin
      @(negedge CLK);
      waitCnt++;
    end
    if (!in_ready) begin
      reportTimeout($sformatf("in_ready before op #%0d", nextId));
      return;
    end
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    if (track) begin
      e.q           = expQ;
      e.r           = expR;
      e.ovf         = expOvf;
      e.acceptCycle = cycleCount;
      e.lat         = lat;
      e.id          = nextId;
      sbQ.push_back(e);
    end
    nextId++;
    @(negedge CLK);
    in_valid = 1'b0;
    dividend = ~dvd;
    divisor  = ~dvs;
  endtask

  // Reference model: plain 64-bit divide, with overflow whenever the
  // quotient cannot be represented in 32 bits.
  task automatic runModel(input logic [63:0] dvd, input logic [31:0] dvs);
    logic [63:0] q64;
    logic [63:0] r64;
    if (dvs == 32'd0 || dvd[63:32] >= dvs) begin
      applyStimulus(dvd, dvs, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1);
    end else begin
      q64 = dvd / {32'd0, dvs};
      r64 = dvd % {32'd0, dvs};
      applyStimulus(dvd, dvs, q64[31:0], r64[31:0], 1'b0, 33, 1'b1);
    end
  endtask

  task automatic drainScoreboard(input string name);
    int waitCnt = 0;
    while (sbQ.size() != 0 && waitCnt < 200) begin
      @(negedge CLK);
      waitCnt++;
    end
    if (sbQ.size() != 0) begin
      reportTimeout(name);
      sbQ.delete();
      seenValid = 1'b0;
    end
  endtask

  // Monitor: samples just after the falling edge, so input changes made on
  // that edge (out_ready) are already visible. Every cycle a result is shown
  // it is compared, which also covers stability under backpressure.
  always begin
    @(negedge CLK);
    #1;
    if (!RST && out_valid) begin
      if (sbQ.size() == 0) begin
        reportTimeout("unexpected out_valid with empty scoreboard");
      end else begin
        monExp = sbQ[0];
        if (!seenValid) begin
          checkOutput($sformatf("latency #%0d", monExp.id),
                      64'(cycleCount - monExp.acceptCycle), 64'(monExp.lat));
          seenValid = 1'b1;
        end
        checkOutput($sformatf("quotient #%0d", monExp.id), 64'(quotient), 64'(monExp.q));
        checkOutput($sformatf("remainder #%0d", monExp.id), 64'(remainder), 64'(monExp.r));
        checkOutput($sformatf("ovf #%0d", monExp.id), 64'(ovf), 64'(monExp.ovf));
        checkOutput($sformatf("chk_err #%0d", monExp.id), 64'(chk_err), 64'd0);
        checkOutput($sformatf("in_ready in DONE #%0d", monExp.id), 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(sbQ.pop_front());
          seenValid = 1'b0;
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    logic [31:0] mx;
    logic [31:0] my;
    logic [63:0] rdvd;
    logic [31:0] rdvs;
    int          waitCnt;

    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset quotient", 64'(quotient), 64'd0);
    checkOutput("reset remainder", 64'(remainder), 64'd0);
    checkOutput("reset ovf", 64'(ovf), 64'd0);
    checkOutput("reset chk_err", 64'(chk_err), 64'd0);
    RST = 1'b0;

    // Directed normal divides and overflow boundaries.
    applyStimulus(64'h0000_0000_0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h2, 1'b0, 33, 1'b1);
    applyStimulus(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33, 1'b1);
    applyStimulus(64'h0000_0000_0000_0123, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b1);
    applyStimulus(64'h0000_0001_0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b1);
    applyStimulus(64'h1234_5678_9ABC_DEF0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b1);
    applyStimulus(64'h0000_0006_FFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 32'h6, 1'b0, 33, 1'b1);
    applyStimulus(64'h1234_5677_FFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5677, 1'b0, 33, 1'b1);
    applyStimulus(64'h0000_0000_0000_0000, 32'h0000_0005, 32'h0, 32'h0, 1'b0, 33, 1'b1);
    applyStimulus(64'h0000_0000_FFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 33, 1'b1);

    // Backpressure: hold the result for 5 cycles with out_ready low.
    drainScoreboard("drain before backpressure");
    out_ready = 1'b0;
    applyStimulus(64'h0000_0001_0000_0000, 32'h0000_0003, 32'h5555_5555, 32'h1, 1'b0, 33, 1'b1);
    waitCnt = 0;
    while (!out_valid && waitCnt < 100) begin
      @(negedge CLK);
      waitCnt++;
    end
    if (!out_valid) reportTimeout("backpressure out_valid");
    repeat (5) @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    checkOutput("post-consume out_valid", 64'(out_valid), 64'd0);
    checkOutput("post-consume in_ready", 64'(in_ready), 64'd1);

    // Reset in the 10th RUN cycle discards the operation in flight.
    drainScoreboard("drain before reset test");
    applyStimulus(64'h0000_0000_1234_5678, 32'h0000_0003, 32'h0, 32'h0, 1'b0, 33, 1'b0);
    repeat (4) @(negedge CLK);
    checkOutput("in_ready during RUN", 64'(in_ready), 64'd0);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("mid-run reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid-run reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid-run reset quotient", 64'(quotient), 64'd0);
    applyStimulus(64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33, 1'b1);

    // Product recovery: dividing mx*my by my must return mx exactly.
    for (int i = 0; i < 13; i++) begin
      case (i)
        0: begin mx = 32'h1234_5678; my = 32'h9ABC_DEF0; end
        1: begin mx = 32'hFFFF_FFFF; my = 32'h0000_0001; end
        2: begin mx = 32'h0000_0001; my = 32'hFFFF_FFFF; end
        3: begin mx = 32'hDEAD_BEEF; my = 32'h0001_0001; end
        4: begin mx = 32'h0000_FFFF; my = 32'hFFFF_0000; end
        default: begin
          mx = $urandom;
          my = $urandom;
          if (my == 32'd0) my = 32'd1;
        end
      endcase
      applyStimulus({32'd0, mx} * {32'd0, my}, my, mx, 32'd0, 1'b0, 33, 1'b1);
    end

    // Unrestricted random pairs against the reference model.
    for (int i = 0; i < 16; i++) begin
      rdvd = {$urandom, $urandom};
      rdvs = $urandom;
      if (i % 2 == 0) rdvd[63:32] = rdvd[63:32] >> $urandom_range(1, 31);
      if (i % 5 == 4) rdvs = 32'($urandom_range(0, 3));
      runModel(rdvd, rdvs);
    end

    drainScoreboard("final drain");
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
